// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: per-producer writeback FIFOs arbitrated round-robin onto
// registered regfile write ports, with a pending-register scoreboard.
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH     = 64,
   parameter int NR_SRC         = 3,
   parameter int NR_WRITE_PORTS = 2,
   parameter int FIFO_DEPTH     = 2
) (
   input  logic                                      clk_i,
   input  logic                                      rst_ni,
   input  logic [NR_SRC-1:0]                         src_valid_i,
   output logic [NR_SRC-1:0]                         src_ready_o,
   input  logic [NR_SRC-1:0][4:0]                    src_waddr_i,
   input  logic [NR_SRC-1:0][DATA_WIDTH-1:0]         src_wdata_i,
   output logic [NR_WRITE_PORTS-1:0][4:0]            waddr_o,
   output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_o,
   output logic [NR_WRITE_PORTS-1:0]                 we_o,
   output logic [31:0]                               pending_o
);
   localparam int SW = $clog2(NR_SRC);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [4:0]            mem_a    [NR_SRC][FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d    [NR_SRC][FIFO_DEPTH];
   logic [AW-1:0]         rd_ptr   [NR_SRC];
   logic [AW-1:0]         wr_ptr   [NR_SRC];
   logic [AW:0]           cnt      [NR_SRC];
   logic [SW-1:0]         rr_ptr, rr_next, idx;
   logic [NR_SRC-1:0]     push, gnt;
   logic [NR_WRITE_PORTS-1:0] port_vld;
   logic [SW-1:0]         port_src [NR_WRITE_PORTS];
   logic [4:0]            port_addr[NR_WRITE_PORTS];
   logic                  dup;
   int                    n;

   always_comb begin
      for (int i = 0; i < NR_SRC; i++) begin
         src_ready_o[i] = cnt[i] != (AW+1)'(FIFO_DEPTH);
         push[i]        = src_valid_i[i] & src_ready_o[i] & (src_waddr_i[i] != 5'd0);
      end
   end

   // Round-robin scan; a head whose address was already granted this cycle waits.
   always_comb begin
      gnt      = '0;
      port_vld = '0;
      rr_next  = rr_ptr;
      n        = 0;
      idx      = '0;
      dup      = 1'b0;
      for (int p = 0; p < NR_WRITE_PORTS; p++) begin
         port_src[p]  = '0;
         port_addr[p] = '0;
      end
      for (int k = 0; k < NR_SRC; k++) begin
         idx = SW'((int'(rr_ptr) + k) % NR_SRC);
         dup = 1'b0;
         for (int p = 0; p < NR_WRITE_PORTS; p++)
            if (p < n && port_addr[p] == mem_a[idx][rd_ptr[idx]]) dup = 1'b1;
         if (cnt[idx] != '0 && n < NR_WRITE_PORTS && !dup) begin
            gnt[idx] = 1'b1;
            for (int p = 0; p < NR_WRITE_PORTS; p++)
               if (p == n) begin
                  port_vld[p]  = 1'b1;
                  port_src[p]  = idx;
                  port_addr[p] = mem_a[idx][rd_ptr[idx]];
               end
            rr_next = SW'((int'(idx) + 1) % NR_SRC);
            n++;
         end
      end
   end

   always_comb begin
      pending_o = '0;
      for (int i = 0; i < NR_SRC; i++)
         for (int j = 0; j < FIFO_DEPTH; j++)
            if ({1'b0, AW'(j) - rd_ptr[i]} < cnt[i]) pending_o[mem_a[i][j]] = 1'b1;
      for (int p = 0; p < NR_WRITE_PORTS; p++)
         if (we_o[p]) pending_o[waddr_o[p]] = 1'b1;
      pending_o[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NR_SRC; i++)
         if (push[i]) begin
            mem_a[i][wr_ptr[i]] <= src_waddr_i[i];
            mem_d[i][wr_ptr[i]] <= src_wdata_i[i];
         end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NR_SRC; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            cnt[i]    <= '0;
         end
         rr_ptr  <= '0;
         we_o    <= '0;
         waddr_o <= '0;
         wdata_o <= '0;
      end else begin
         for (int i = 0; i < NR_SRC; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (gnt[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
            cnt[i] <= cnt[i] + (AW+1)'(push[i]) - (AW+1)'(gnt[i]);
         end
         rr_ptr <= rr_next;
         we_o   <= port_vld;
         for (int p = 0; p < NR_WRITE_PORTS; p++)
            if (port_vld[p]) begin
               waddr_o[p] <= port_addr[p];
               wdata_o[p] <= mem_d[port_src[p]][rd_ptr[port_src[p]]];
            end
      end
   end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001: Parameter DATA_WIDTH, default 64, width of written data.
REQ-002: Parameter NR_SRC, default 3, number of writeback producers (range 2..4).
REQ-003: Parameter NR_WRITE_PORTS, default 2, regfile write ports driven (1..NR_SRC).
REQ-004: Parameter FIFO_DEPTH, default 2, entries buffered per producer (power of two, at least 2).
REQ-005: clk_i  input  1  clock; all state updates on the rising edge.
REQ-006: rst_ni  input  1  reset, asynchronous, active-low.
REQ-007: src_valid_i  input  NR_SRC  producer i presents a write.
REQ-008: src_ready_o  output  NR_SRC  producer i may push this cycle.
REQ-009: src_waddr_i  input  NR_SRC x 5  destination register per producer.
REQ-010: src_wdata_i  input  NR_SRC x DATA_WIDTH  write data per producer.
REQ-011: waddr_o  output  NR_WRITE_PORTS x 5  regfile write address, registered.
REQ-012: wdata_o  output  NR_WRITE_PORTS x DATA_WIDTH  regfile write data, registered.
REQ-013: we_o  output  NR_WRITE_PORTS  regfile write enable, registered.
REQ-014: pending_o  output  32  bit r set while any buffered or output-staged write targets register r.

Function
REQ-015: Push into FIFO i when src_valid_i[i] and src_ready_o[i] are both 1 on a rising edge.
REQ-016: src_ready_o[i] = FIFO i not full; depends only on state, never on valid or same-cycle pop (full FIFO with pop still shows ready 0).
REQ-017: Push with src_waddr_i = 0 is accepted but discarded: not stored, never drives we_o.
REQ-018: Each cycle scan FIFO heads in order rr_ptr, rr_ptr+1, ... modulo NR_SRC; grant up to NR_WRITE_PORTS non-empty heads; first grant -> port 0, second -> port 1, etc.
REQ-019: A head whose address equals an already-granted head's address in the same scan is skipped this cycle (no two ports carry the same address in one cycle); it stays at head.
REQ-020: Granted heads pop on the same edge; their address/data load into waddr_o/wdata_o of the assigned port with we_o = 1; unassigned ports load we_o = 0, waddr_o/wdata_o hold previous value.
REQ-021: Latency: write pushed at edge N into an empty FIFO, with no competition, appears with we_o = 1 in the cycle after edge N+1 (one cycle buffering, one cycle output register).
REQ-022: Per-producer order preserved: writes from one producer reach we_o in push order.
REQ-023: rr_ptr becomes (index of last granted source + 1) mod NR_SRC when at least one grant occurs; otherwise unchanged.
REQ-024: Push and pop of the same FIFO in the same cycle both take effect; count unchanged.
REQ-025: FIFO read/write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-026: pending_o[r] = OR over all valid FIFO entries and all ports with we_o = 1 of (address == r); pending_o[0] always 0; combinational from state.
REQ-027: No flush: accepted writes are architecturally committed and always reach we_o.

Reset
REQ-028: While rst_ni = 0: all FIFOs empty, rr_ptr = 0, we_o = 0, waddr_o = 0, wdata_o = 0, src_ready_o all 1, pending_o = 0.
REQ-029: Reset asserted mid-operation discards all buffered and staged writes immediately (asynchronous), without producing a write pulse.

Verification
REQ-030: Single push src0 addr 5 data 0xA5 at edge 1 -> we_o[0]=1, waddr_o[0]=5, wdata_o[0]=0xA5 in the cycle after edge 2; pending_o[5]=1 from edge 1 until we_o drops.
REQ-031: Three producers push addrs 1,2,3 simultaneously from reset (rr_ptr=0) -> next output cycle ports carry 1,2; following cycle port 0 carries 3, port 1 we_o=0; rr_ptr ends at 0.
REQ-032: src0 and src1 both push addr 7 (data 0x11, 0x22) same cycle, rr_ptr=0 -> cycle k: one port writes 0x11, other we_o=0; cycle k+1: write 0x22 to 7; final regfile value 0x22.
REQ-033: src2 pushes 3 writes back-to-back with FIFO_DEPTH=2 and other sources idle -> src_ready_o[2] drops after second push only if head not yet popped; all three arrive in order, none lost.
REQ-034: Push to addr 0 -> src_ready_o stays 1, we_o never asserted, pending_o unchanged.
REQ-035: Assert rst_ni=0 with two entries buffered and we_o=1 -> we_o, pending_o, waddr_o clear immediately; after release no stale write appears.
